// File: rtl/frog_game_ctrl.sv
// frog_game_ctrl: owns frog position, facing, lives and score, and sequences IDLE/PLAY/DYING/OVER per frame.
// Optional macro FROG_INVINCIBLE_EN forces the death condition off for lane-layout bring-up.
module frog_game_ctrl #(
    parameter int unsigned GRID         = 40,
    parameter int unsigned START_X      = 320,
    parameter int unsigned START_Y      = 440,
    parameter int unsigned GOAL_Y       = 0,
    parameter int unsigned MAX_X        = 600,
    parameter int unsigned MAX_Y        = 440,
    parameter int unsigned LIVES        = 3,
    parameter int unsigned DEATH_FRAMES = 60
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_left,
    input  logic        key_right,
    input  logic [3:0]  Car_Collision,
    input  logic [3:0]  Water_Row,
    input  logic [3:0]  LPad_Collision,
    output logic [10:0] FrogX,
    output logic [10:0] FrogY,
    output logic        up,
    output logic        down,
    output logic        left,
    output logic        right,
    output logic [1:0]  lives,
    output logic [7:0]  score,
    output logic [1:0]  game_state,
    output logic        dying
);
    localparam int unsigned POS_W = 11;
    localparam int unsigned CNT_W = (DEATH_FRAMES > 2) ? $clog2(DEATH_FRAMES) : 1;

    localparam logic [POS_W-1:0] C_GRID    = POS_W'(GRID);
    localparam logic [POS_W-1:0] C_START_X = POS_W'(START_X);
    localparam logic [POS_W-1:0] C_START_Y = POS_W'(START_Y);
    localparam logic [POS_W-1:0] C_GOAL_Y  = POS_W'(GOAL_Y);
    localparam logic [POS_W:0]   C_MAX_X   = (POS_W+1)'(MAX_X);
    localparam logic [POS_W:0]   C_MAX_Y   = (POS_W+1)'(MAX_Y);
    localparam logic [1:0]       C_LIVES   = 2'(LIVES);
    localparam logic [CNT_W-1:0] C_CNT_INI = CNT_W'(DEATH_FRAMES - 1);

    localparam logic [3:0] F_UP    = 4'b1000;
    localparam logic [3:0] F_DOWN  = 4'b0100;
    localparam logic [3:0] F_LEFT  = 4'b0010;
    localparam logic [3:0] F_RIGHT = 4'b0001;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_DYING = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t           r_state;
    logic [POS_W-1:0] r_x;
    logic [POS_W-1:0] r_y;
    logic [3:0]       r_face;
    logic [1:0]       r_lives;
    logic [7:0]       r_score;
    logic             r_dying;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_keys;
    logic [3:0]       r_pend;

    logic [3:0]       w_keys;
    logic [3:0]       w_rise;
    logic [3:0]       w_new_pend;
    logic             w_pending;
    logic             w_death;
    logic             w_hold_pend;
    logic [POS_W:0]   w_x_sum;
    logic [POS_W:0]   w_y_sum;
    logic [POS_W-1:0] w_nx;
    logic [POS_W-1:0] w_ny;
    logic [3:0]       w_nface;

    assign w_keys    = {key_up, key_down, key_left, key_right};
    assign w_rise    = w_keys & ~r_keys;
    assign w_pending = |r_pend;
    assign w_x_sum   = {1'b0, r_x} + {1'b0, C_GRID};
    assign w_y_sum   = {1'b0, r_y} + {1'b0, C_GRID};
    // Pending hop survives ticks only while the death counter is still running.
    assign w_hold_pend = (r_state == S_DYING) && (r_cnt != '0);

`ifdef FROG_INVINCIBLE_EN
    assign w_death = 1'b0;
`else
    assign w_death = (|Car_Collision) | (|(Water_Row & ~LPad_Collision));
`endif

    // Simultaneous edges resolve up > down > left > right.
    always_comb begin
        w_new_pend = 4'b0000;
        if (w_rise[3])      w_new_pend = F_UP;
        else if (w_rise[2]) w_new_pend = F_DOWN;
        else if (w_rise[1]) w_new_pend = F_LEFT;
        else if (w_rise[0]) w_new_pend = F_RIGHT;
    end

    // Candidate position after the pending hop; out-of-range hops leave position unchanged.
    always_comb begin
        w_nx    = r_x;
        w_ny    = r_y;
        w_nface = r_face;
        if (r_pend[3]) begin
            w_nface = F_UP;
            if (r_y >= C_GRID) w_ny = r_y - C_GRID;
        end else if (r_pend[2]) begin
            w_nface = F_DOWN;
            if (w_y_sum <= C_MAX_Y) w_ny = w_y_sum[POS_W-1:0];
        end else if (r_pend[1]) begin
            w_nface = F_LEFT;
            if (r_x >= C_GRID) w_nx = r_x - C_GRID;
        end else if (r_pend[0]) begin
            w_nface = F_RIGHT;
            if (w_x_sum <= C_MAX_X) w_nx = w_x_sum[POS_W-1:0];
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_x     <= C_START_X;
            r_y     <= C_START_Y;
            r_face  <= F_UP;
            r_lives <= C_LIVES;
            r_score <= 8'd0;
            r_dying <= 1'b0;
            r_cnt   <= '0;
            r_keys  <= 4'b0000;
            r_pend  <= 4'b0000;
        end else begin
            r_keys <= w_keys;
            if (w_rise != 4'b0000)
                r_pend <= w_new_pend;
            else if (frame_tick && !w_hold_pend)
                r_pend <= 4'b0000;

            if (frame_tick) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_pending) r_state <= S_PLAY;
                    end
                    S_PLAY: begin
                        if (w_death) begin
                            r_state <= S_DYING;
                            r_dying <= 1'b1;
                            r_cnt   <= C_CNT_INI;
                            r_lives <= r_lives - 2'd1;
                        end else if (w_ny == C_GOAL_Y) begin
                            r_score <= (r_score == 8'hFF) ? r_score : r_score + 8'd1;
                            r_x     <= C_START_X;
                            r_y     <= C_START_Y;
                            r_face  <= F_UP;
                        end else begin
                            r_x    <= w_nx;
                            r_y    <= w_ny;
                            r_face <= w_nface;
                        end
                    end
                    S_DYING: begin
                        if (r_cnt == '0) begin
                            r_dying <= 1'b0;
                            if (r_lives == 2'd0) begin
                                r_state <= S_OVER;
                            end else begin
                                r_state <= S_PLAY;
                                r_x     <= C_START_X;
                                r_y     <= C_START_Y;
                                r_face  <= F_UP;
                            end
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    S_OVER: begin
                        if (w_pending) begin
                            r_state <= S_IDLE;
                            r_lives <= C_LIVES;
                            r_score <= 8'd0;
                            r_x     <= C_START_X;
                            r_y     <= C_START_Y;
                            r_face  <= F_UP;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign FrogX      = r_x;
    assign FrogY      = r_y;
    assign up         = r_face[3];
    assign down       = r_face[2];
    assign left       = r_face[1];
    assign right      = r_face[0];
    assign lives      = r_lives;
    assign score      = r_score;
    assign game_state = r_state;
    assign dying      = r_dying;

endmodule

// File: tb/tb_frog_game_ctrl.sv
// tb_frog_game_ctrl: table-driven per-frame vectors with a scoreboard queue, plus hand sequences for
// key-edge/tick coincidence and asynchronous reset in mid-game.
module tb_frog_game_ctrl;
    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [3:0]  face;
        logic [1:0]  lives;
        logic [7:0]  score;
        logic [1:0]  state;
        logic        dying;
    } out_t;

    typedef struct {
        logic [3:0] keys;
        logic       hold;
        logic [3:0] car;
        logic [3:0] water;
        logic [3:0] lpad;
        int         n;
        out_t       exp;
    } vec_t;

    localparam logic [3:0] K0  = 4'b0000;
    localparam logic [3:0] F_U = 4'b1000;
    localparam logic [3:0] F_D = 4'b0100;
    localparam logic [3:0] F_L = 4'b0010;
    localparam logic [3:0] F_R = 4'b0001;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_tick = 1'b0;
    logic [3:0]  keys = 4'b0000;
    logic [3:0]  car = 4'b0000;
    logic [3:0]  water = 4'b0000;
    logic [3:0]  lpad = 4'b0000;
    logic [10:0] FrogX, FrogY;
    logic        up, down, left, right;
    logic [1:0]  lives;
    logic [7:0]  score;
    logic [1:0]  game_state;
    logic        dying;

    vec_t vecs[$];
    out_t sb[$];
    int   checks = 0;
    int   errors = 0;

    frog_game_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick),
        .key_up(keys[3]), .key_down(keys[2]), .key_left(keys[1]), .key_right(keys[0]),
        .Car_Collision(car), .Water_Row(water), .LPad_Collision(lpad),
        .FrogX(FrogX), .FrogY(FrogY),
        .up(up), .down(down), .left(left), .right(right),
        .lives(lives), .score(score), .game_state(game_state), .dying(dying)
    );

    always #5 Clk = ~Clk;

    function automatic out_t mo(int x, int y, logic [3:0] f, int l, int s, int st, logic d);
        out_t o;
        o.x = 11'(x); o.y = 11'(y); o.face = f; o.lives = 2'(l);
        o.score = 8'(s); o.state = 2'(st); o.dying = d;
        return o;
    endfunction

    function automatic vec_t mk(logic [3:0] k, logic h, logic [3:0] c, logic [3:0] w,
                                logic [3:0] p, int n, out_t e);
        vec_t v;
        v.keys = k; v.hold = h; v.car = c; v.water = w; v.lpad = p; v.n = n; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name);
        out_t got, exp;
        got.x = FrogX; got.y = FrogY; got.face = {up, down, left, right};
        got.lives = lives; got.score = score; got.state = game_state; got.dying = dying;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: no expected entry queued", name);
            return;
        end
        exp = sb.pop_front();
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got x=%0d y=%0d face=%b lives=%0d score=%0d state=%0d dying=%b, expected x=%0d y=%0d face=%b lives=%0d score=%0d state=%0d dying=%b",
                     name, got.x, got.y, got.face, got.lives, got.score, got.state, got.dying,
                     exp.x, exp.y, exp.face, exp.lives, exp.score, exp.state, exp.dying);
        end
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        @(negedge Clk);
    endtask

    task automatic apply(input vec_t v, input string name);
        if (!v.hold) begin
            keys = K0;
            @(negedge Clk); @(negedge Clk);
        end
        keys = v.keys;
        @(negedge Clk); @(negedge Clk);
        car = v.car; water = v.water; lpad = v.lpad;
        sb.push_back(v.exp);
        for (int i = 0; i < v.n; i++) tick();
        check(name);
        car = K0; water = K0; lpad = K0;
    endtask

    initial begin
        // Reset state, first press leaves IDLE without moving, hold gives one hop, down clamp.
        vecs.push_back(mk(K0,  0, K0, K0, K0, 0, mo(320, 440, F_U, 3, 0, 0, 0)));
        vecs.push_back(mk(K0,  0, K0, K0, K0, 1, mo(320, 440, F_U, 3, 0, 0, 0)));
        vecs.push_back(mk(F_U, 0, K0, K0, K0, 1, mo(320, 440, F_U, 3, 0, 1, 0)));
        vecs.push_back(mk(K0,  0, K0, K0, K0, 1, mo(320, 440, F_U, 3, 0, 1, 0)));
        vecs.push_back(mk(F_U, 0, K0, K0, K0, 1, mo(320, 400, F_U, 3, 0, 1, 0)));
        vecs.push_back(mk(F_U, 1, K0, K0, K0, 5, mo(320, 400, F_U, 3, 0, 1, 0)));
        vecs.push_back(mk(F_D, 0, K0, K0, K0, 1, mo(320, 440, F_D, 3, 0, 1, 0)));
        vecs.push_back(mk(F_D, 0, K0, K0, K0, 1, mo(320, 440, F_D, 3, 0, 1, 0)));
        for (int i = 1; i <= 8; i++)
            vecs.push_back(mk(F_L, 0, K0, K0, K0, 1, mo(320 - 40 * i, 440, F_L, 3, 0, 1, 0)));
        vecs.push_back(mk(F_L, 0, K0, K0, K0, 1, mo(0, 440, F_L, 3, 0, 1, 0)));
        vecs.push_back(mk(F_D, 0, K0, K0, K0, 1, mo(0, 440, F_D, 3, 0, 1, 0)));
        vecs.push_back(mk(F_R, 0, K0, K0, K0, 1, mo(40, 440, F_R, 3, 0, 1, 0)));
        for (int i = 1; i <= 14; i++)
            vecs.push_back(mk(F_R, 0, K0, K0, K0, 1, mo(40 + 40 * i, 440, F_R, 3, 0, 1, 0)));
        vecs.push_back(mk(F_R, 0, K0, K0, K0, 1, mo(600, 440, F_R, 3, 0, 1, 0)));
        for (int i = 1; i <= 10; i++)
            vecs.push_back(mk(F_U, 0, K0, K0, K0, 1, mo(600, 440 - 40 * i, F_U, 3, 0, 1, 0)));
        // Goal scores and respawns on the same tick.
        vecs.push_back(mk(F_U, 0, K0, K0, K0, 1, mo(320, 440, F_U, 3, 1, 1, 0)));
        // Hop plus car hit: death wins, facing and position untouched.
        vecs.push_back(mk(F_L, 0, 4'b0010, K0, K0, 1, mo(320, 440, F_U, 2, 1, 2, 1)));
        vecs.push_back(mk(K0,  0, K0, K0, K0, 59, mo(320, 440, F_U, 2, 1, 2, 1)));
        vecs.push_back(mk(K0,  0, K0, K0, K0, 1,  mo(320, 440, F_U, 2, 1, 1, 0)));
        vecs.push_back(mk(K0,  0, K0, 4'b0100, K0, 1, mo(320, 440, F_U, 1, 1, 2, 1)));
        vecs.push_back(mk(K0,  0, K0, K0, K0, 60, mo(320, 440, F_U, 1, 1, 1, 0)));
        vecs.push_back(mk(K0,  0, K0, 4'b0100, 4'b0100, 1, mo(320, 440, F_U, 1, 1, 1, 0)));
        vecs.push_back(mk(K0,  0, K0, 4'b0100, K0, 1, mo(320, 440, F_U, 0, 1, 2, 1)));
        vecs.push_back(mk(K0,  0, K0, K0, K0, 60, mo(320, 440, F_U, 0, 1, 3, 0)));
        vecs.push_back(mk(K0,  0, K0, K0, K0, 1,  mo(320, 440, F_U, 0, 1, 3, 0)));
        vecs.push_back(mk(F_R, 0, K0, K0, K0, 1,  mo(320, 440, F_U, 3, 0, 0, 0)));

        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Enter PLAY, then a key edge on the tick cycle must wait for the following tick.
        apply(mk(F_U, 0, K0, K0, K0, 1, mo(320, 440, F_U, 3, 0, 1, 0)), "edge_enter_play");
        keys = K0;
        @(negedge Clk); @(negedge Clk);
        keys = F_U;
        sb.push_back(mo(320, 440, F_U, 3, 0, 1, 0));
        tick();
        check("edge_on_tick_deferred");
        sb.push_back(mo(320, 400, F_U, 3, 0, 1, 0));
        tick();
        check("edge_on_tick_next");

        // Asynchronous reset takes effect without a clock edge.
        @(negedge Clk);
        Reset = 1'b1;
        sb.push_back(mo(320, 440, F_U, 3, 0, 0, 0));
        #1;
        check("async_reset");
        keys = K0;
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
